// File: rtl/dct8_odd_mac.sv
// ---------------------------------------------------------------------------
// dct8_odd_mac : serial multiplier-free MAC for the odd half of an 8-point DCT
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dct8_odd_mac #(
  parameter int OUT_SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic signed [18:0] i_data,
  input  logic               i_clear,
  output logic               o_valid,
  output logic signed [27:0] o_data_0,
  output logic signed [27:0] o_data_1,
  output logic signed [27:0] o_data_2,
  output logic signed [27:0] o_data_3,
  output logic               o_busy
);

  logic        [1:0]  idx_q, idx_d;
  logic signed [27:0] acc_q [4];
  logic signed [27:0] out_q [4];
  logic               valid_q;
  logic               busy_q;

  logic signed [25:0] w_d, w_p89, w_p75, w_p50, w_p18;
  logic signed [27:0] w_e89, w_e75, w_e50, w_e18;
  logic signed [27:0] w_term [4];
  logic signed [27:0] w_sum  [4];
  logic signed [27:0] w_res  [4];
  logic               w_accept;

  assign w_d   = {{7{i_data[18]}}, i_data};
  assign w_p89 = (w_d <<< 6) + (w_d <<< 4) + (w_d <<< 3) + w_d;
  assign w_p75 = (w_d <<< 6) + (w_d <<< 3) + (w_d <<< 1) + w_d;
  assign w_p50 = (w_d <<< 5) + (w_d <<< 4) + (w_d <<< 1);
  assign w_p18 = (w_d <<< 4) + (w_d <<< 1);

  assign w_e89 = {{2{w_p89[25]}}, w_p89};
  assign w_e75 = {{2{w_p75[25]}}, w_p75};
  assign w_e50 = {{2{w_p50[25]}}, w_p50};
  assign w_e18 = {{2{w_p18[25]}}, w_p18};

  assign w_accept = i_valid & ~i_clear;

  // Coefficient column of the odd DCT-8 matrix selected by the sample index
  always_comb begin
    w_term[0] = '0;
    w_term[1] = '0;
    w_term[2] = '0;
    w_term[3] = '0;
    case (idx_q)
      2'd0: begin w_term[0] =  w_e89; w_term[1] =  w_e75; w_term[2] =  w_e50; w_term[3] =  w_e18; end
      2'd1: begin w_term[0] =  w_e75; w_term[1] = -w_e18; w_term[2] = -w_e89; w_term[3] = -w_e50; end
      2'd2: begin w_term[0] =  w_e50; w_term[1] = -w_e89; w_term[2] =  w_e18; w_term[3] =  w_e75; end
      default: begin w_term[0] = w_e18; w_term[1] = -w_e50; w_term[2] = w_e75; w_term[3] = -w_e89; end
    endcase
  end

  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_sum[j] = (idx_q == 2'd0) ? w_term[j] : acc_q[j] + w_term[j];
    end
  end

  generate
    if (OUT_SHIFT > 0) begin : g_round
      localparam logic signed [27:0] c_RND = 28'sd1 <<< (OUT_SHIFT - 1);
      always_comb begin
        for (int j = 0; j < 4; j++) begin
          w_res[j] = (w_sum[j] + c_RND) >>> OUT_SHIFT;
        end
      end
    end else begin : g_raw
      always_comb begin
        for (int j = 0; j < 4; j++) begin
          w_res[j] = w_sum[j];
        end
      end
    end
  endgenerate

  always_comb begin
    idx_d = idx_q;
    if (i_clear) begin
      idx_d = 2'd0;
    end else if (i_valid) begin
      idx_d = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int j = 0; j < 4; j++) begin
        acc_q[j] <= '0;
        out_q[j] <= '0;
      end
    end else begin
      idx_q   <= idx_d;
      busy_q  <= (idx_d != 2'd0);
      valid_q <= 1'b0;
      if (w_accept) begin
        for (int j = 0; j < 4; j++) begin
          acc_q[j] <= w_sum[j];
        end
        if (idx_q == 2'd3) begin
          valid_q <= 1'b1;
          for (int j = 0; j < 4; j++) begin
            out_q[j] <= w_res[j];
          end
        end
      end
    end
  end

  assign o_valid  = valid_q;
  assign o_busy   = busy_q;
  assign o_data_0 = out_q[0];
  assign o_data_1 = out_q[1];
  assign o_data_2 = out_q[2];
  assign o_data_3 = out_q[3];

endmodule

`default_nettype wire

// File: tb/tb_dct8_odd_mac.sv
// ---------------------------------------------------------------------------
// tb_dct8_odd_mac : directed self-checking bench, raw and OUT_SHIFT=2 instances
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dct8_odd_mac;

  logic               clk;
  logic               rst;
  logic               i_valid;
  logic signed [18:0] i_data;
  logic               i_clear;

  logic               a_valid, a_busy;
  logic signed [27:0] a_d0, a_d1, a_d2, a_d3;
  logic               b_valid, b_busy;
  logic signed [27:0] b_d0, b_d1, b_d2, b_d3;

  int total;
  int bad;
  int pulses_a;
  int pulses_b;

  dct8_odd_mac #(.OUT_SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_clear(i_clear),
    .o_valid(a_valid), .o_data_0(a_d0), .o_data_1(a_d1), .o_data_2(a_d2),
    .o_data_3(a_d3), .o_busy(a_busy)
  );

  dct8_odd_mac #(.OUT_SHIFT(2)) dut_b (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data), .i_clear(i_clear),
    .o_valid(b_valid), .o_data_0(b_d0), .o_data_1(b_d1), .o_data_2(b_d2),
    .o_data_3(b_d3), .o_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_valid === 1'b1) pulses_a++;
    if (b_valid === 1'b1) pulses_b++;
  end

  task automatic step(input logic v, input logic c, input logic signed [18:0] d);
    i_valid = v;
    i_clear = c;
    i_data  = d;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b0, 19'sd5);
    step(1'b0, 1'b0, 19'sd0);
    total++;
    if ({a_valid, a_busy} !== 2'b00 || a_d0 !== 0 || a_d1 !== 0 || a_d2 !== 0 || a_d3 !== 0) begin
      bad++;
      $display("FAIL reset: valid=%0b busy=%0b d=%0d,%0d,%0d,%0d required all 0",
               a_valid, a_busy, a_d0, a_d1, a_d2, a_d3);
    end
    rst = 1'b0;
  endtask

  task automatic test_impulse();
    step(1'b1, 1'b0, 19'sd1);
    total++;
    if (a_busy !== 1'b1) begin
      bad++; $display("FAIL impulse_busy: busy=%0b required 1", a_busy);
    end
    step(1'b1, 1'b0, 19'sd0);
    step(1'b1, 1'b0, 19'sd0);
    step(1'b1, 1'b0, 19'sd0);
    total++;
    if (a_valid !== 1'b1 || a_busy !== 1'b0 || a_d0 !== 89 || a_d1 !== 75 || a_d2 !== 50 || a_d3 !== 18) begin
      bad++;
      $display("FAIL impulse: valid=%0b busy=%0b O=%0d,%0d,%0d,%0d required 1 0 89,75,50,18",
               a_valid, a_busy, a_d0, a_d1, a_d2, a_d3);
    end
    total++;
    if (b_d0 !== 22 || b_d1 !== 19 || b_d2 !== 13 || b_d3 !== 5) begin
      bad++;
      $display("FAIL impulse_shift2: O=%0d,%0d,%0d,%0d required 22,19,13,5", b_d0, b_d1, b_d2, b_d3);
    end
    step(1'b0, 1'b0, 19'sd0);
    step(1'b0, 1'b0, 19'sd0);
    total++;
    if (a_valid !== 1'b0 || a_d0 !== 89 || a_d3 !== 18) begin
      bad++;
      $display("FAIL hold: valid=%0b O0=%0d O3=%0d required 0 89 18", a_valid, a_d0, a_d3);
    end
  endtask

  task automatic test_all_ones();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 19'sd1);
    total++;
    if (a_valid !== 1'b1 || a_d0 !== 232 || a_d1 !== -82 || a_d2 !== 54 || a_d3 !== -46) begin
      bad++;
      $display("FAIL all_ones: valid=%0b O=%0d,%0d,%0d,%0d required 1 232,-82,54,-46",
               a_valid, a_d0, a_d1, a_d2, a_d3);
    end
    total++;
    if (b_valid !== 1'b1 || b_d0 !== 58 || b_d1 !== -20 || b_d2 !== 14 || b_d3 !== -11) begin
      bad++;
      $display("FAIL all_ones_shift2: valid=%0b O=%0d,%0d,%0d,%0d required 1 58,-20,14,-11",
               b_valid, b_d0, b_d1, b_d2, b_d3);
    end
    step(1'b0, 1'b0, 19'sd0);
  endtask

  task automatic test_extremes();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, -19'sd262144);
    total++;
    if (a_d0 !== -60817408 || a_d1 !== 21495808) begin
      bad++;
      $display("FAIL extreme_neg: O0=%0d O1=%0d required -60817408 21495808", a_d0, a_d1);
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 19'sd262143);
    total++;
    if (a_d0 !== 60817176) begin
      bad++;
      $display("FAIL extreme_pos: O0=%0d required 60817176", a_d0);
    end
    step(1'b0, 1'b0, 19'sd0);
  endtask

  task automatic test_back_to_back();
    int p0;
    p0 = pulses_a;
    step(1'b1, 1'b0, 19'sd1);
    step(1'b1, 1'b0, 19'sd0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 19'sd0);
    total++;
    if (a_busy !== 1'b1 || a_valid !== 1'b0) begin
      bad++; $display("FAIL stall_busy: busy=%0b valid=%0b required 1 0", a_busy, a_valid);
    end
    step(1'b1, 1'b0, 19'sd0);
    step(1'b1, 1'b0, 19'sd0);
    total++;
    if (a_valid !== 1'b1 || a_d0 !== 89 || a_d1 !== 75) begin
      bad++;
      $display("FAIL stall_group: valid=%0b O0=%0d O1=%0d required 1 89 75", a_valid, a_d0, a_d1);
    end
    step(1'b1, 1'b0, 19'sd0);
    step(1'b1, 1'b0, 19'sd0);
    step(1'b1, 1'b0, 19'sd0);
    step(1'b1, 1'b0, 19'sd1);
    total++;
    if (a_valid !== 1'b1 || a_d0 !== 18 || a_d1 !== -50 || a_d2 !== 75 || a_d3 !== -89) begin
      bad++;
      $display("FAIL b2b_group: valid=%0b O=%0d,%0d,%0d,%0d required 1 18,-50,75,-89",
               a_valid, a_d0, a_d1, a_d2, a_d3);
    end
    step(1'b0, 1'b0, 19'sd0);
    total++;
    if (pulses_a - p0 !== 2) begin
      bad++; $display("FAIL b2b_pulses: got=%0d required 2", pulses_a - p0);
    end
  endtask

  task automatic test_clear();
    int p0;
    p0 = pulses_a;
    step(1'b1, 1'b0, 19'sd5);
    step(1'b1, 1'b0, 19'sd7);
    step(1'b1, 1'b1, 19'sd100);
    total++;
    if (a_busy !== 1'b0 || a_valid !== 1'b0 || a_d0 !== 18) begin
      bad++;
      $display("FAIL clear: busy=%0b valid=%0b O0=%0d required 0 0 18", a_busy, a_valid, a_d0);
    end
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 19'sd1);
    total++;
    if (a_valid !== 1'b1 || a_d0 !== 232 || a_d1 !== -82 || a_d2 !== 54 || a_d3 !== -46) begin
      bad++;
      $display("FAIL clear_group: valid=%0b O=%0d,%0d,%0d,%0d required 1 232,-82,54,-46",
               a_valid, a_d0, a_d1, a_d2, a_d3);
    end
    step(1'b0, 1'b0, 19'sd0);
    total++;
    if (pulses_a - p0 !== 1) begin
      bad++; $display("FAIL clear_pulses: got=%0d required 1", pulses_a - p0);
    end
  endtask

  task automatic test_reset_mid();
    int p0;
    p0 = pulses_a;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 19'sd9);
    rst = 1'b1;
    step(1'b1, 1'b0, 19'sd9);
    rst = 1'b0;
    total++;
    if ({a_valid, a_busy} !== 2'b00 || a_d0 !== 0 || a_d1 !== 0 || a_d2 !== 0 || a_d3 !== 0) begin
      bad++;
      $display("FAIL reset_mid: valid=%0b busy=%0b O=%0d,%0d,%0d,%0d required all 0",
               a_valid, a_busy, a_d0, a_d1, a_d2, a_d3);
    end
    step(1'b1, 1'b0, 19'sd2);
    step(1'b1, 1'b0, -19'sd1);
    step(1'b1, 1'b0, 19'sd3);
    step(1'b1, 1'b0, 19'sd0);
    total++;
    if (a_valid !== 1'b1 || a_d0 !== 253 || a_d1 !== -99 || a_d2 !== 243 || a_d3 !== 311) begin
      bad++;
      $display("FAIL reset_mid_group: valid=%0b O=%0d,%0d,%0d,%0d required 1 253,-99,243,311",
               a_valid, a_d0, a_d1, a_d2, a_d3);
    end
    step(1'b0, 1'b0, 19'sd0);
    total++;
    if (pulses_a - p0 !== 1) begin
      bad++; $display("FAIL reset_mid_pulses: got=%0d required 1", pulses_a - p0);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    pulses_a = 0;
    pulses_b = 0;
    rst      = 1'b1;
    i_valid  = 1'b0;
    i_clear  = 1'b0;
    i_data   = '0;
    test_reset();
    test_impulse();
    test_all_ones();
    test_extremes();
    test_back_to_back();
    test_clear();
    test_reset_mid();
    total++;
    if (pulses_b !== pulses_a) begin
      bad++; $display("FAIL pulse_match: shift2=%0d required %0d", pulses_b, pulses_a);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dct8_odd_mac.md
DCT8_ODD_MAC -- requirements
Module: dct8_odd_mac

Interface
REQ-001 SHALL have parameter OUT_SHIFT, default 0, meaning arithmetic right-shift with round-half-up applied to each sum before output; legal range 0..7.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port i_valid  input  1  i_data carries the next odd-difference sample this cycle.
REQ-005 SHALL have port i_data  input  19  signed odd-difference sample d[k], k = 0..3 in arrival order.
REQ-006 SHALL have port i_clear  input  1  discard any partially accumulated group.
REQ-007 SHALL have port o_valid  output  1  one-cycle pulse; o_data_0..3 hold a completed group.
REQ-008 SHALL have ports o_data_0, o_data_1, o_data_2, o_data_3  output  28 each  signed odd DCT-8 outputs O0..O3.
REQ-009 SHALL have port o_busy  output  1  high while 1..3 samples of a group have been accepted.

Function
REQ-010 SHALL accept a sample on every cycle with i_valid=1 and i_clear=0; there is no backpressure.
REQ-011 SHALL keep a 2-bit sample index idx, 0..3, that advances on each accepted sample and wraps from 3 to 0.
REQ-012 SHALL form products of d[k] with 89, 75, 50 and 18 by shift-add only (no multiplier), each product 26-bit signed.
REQ-013 SHALL accumulate, in 28-bit signed arithmetic:
  - O0 = 89d0 + 75d1 + 50d2 + 18d3
  - O1 = 75d0 - 18d1 - 89d2 - 50d3
  - O2 = 50d0 - 89d1 + 18d2 + 75d3
  - O3 = 18d0 - 50d1 + 75d2 - 89d3
REQ-014 SHALL load the accumulators with the signed product at idx=0, not add to the previous contents.
REQ-015 SHALL, when the idx=3 sample is accepted at cycle N, register the final sums into o_data_0..3 and assert o_valid at cycle N+1 (latency 1 from the last sample).
REQ-016 SHALL, when OUT_SHIFT>0, output (sum + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, sign-extended to 28 bits; when OUT_SHIFT=0, output the raw sum.
REQ-017 SHALL hold o_data_0..3 unchanged between o_valid pulses.
REQ-018 SHALL support back-to-back groups: an idx=0 sample accepted in the cycle o_valid is high starts a new group with no bubble.
REQ-019 SHALL freeze idx and the accumulators while i_valid=0; gaps of any length are allowed mid-group.
REQ-020 SHALL, when i_clear=1, reset idx to 0, ignore i_valid that cycle and suppress o_valid for the discarded group; o_data is not altered.
REQ-021 SHALL give i_clear priority over i_valid when both are asserted in the same cycle.
REQ-022 SHALL drive o_busy = (idx != 0), registered.
REQ-023 SHALL never overflow: the worst case |sum| = 232 * 2^18 = 60817408 < 2^27.

Reset
REQ-024 SHALL, while rst=1, set idx=0, clear the accumulators, o_valid=0, o_busy=0 and o_data_0..3=0.
REQ-025 SHALL give rst priority over i_clear and i_valid.
REQ-026 SHALL discard a partial group when reset arrives mid-group, with no o_valid pulse for it.

Verification
REQ-027 SHALL check impulse: d = 1,0,0,0 with OUT_SHIFT=0 -> one cycle after the 4th sample, o_valid=1 and O = 89, 75, 50, 18.
REQ-028 SHALL check all-ones: d = 1,1,1,1 -> O = 232, -82, 54, -46; then with OUT_SHIFT=2 -> 58, -20, 14, -11.
REQ-029 SHALL check extremes: d = -262144, -262144, -262144, -262144 -> O0 = -60817408 with no wrap; d = 262143 x4 -> O0 = 60817176.
REQ-030 SHALL check stall plus back-to-back: group 1,0,0,0 with 3 idle cycles after sample 2, followed immediately by group 0,0,0,1 -> two o_valid pulses; the second gives O = 18, -50, 75, -89.
REQ-031 SHALL check clear mid-group: 2 samples, then i_clear together with i_valid, then 1,1,1,1 -> exactly one o_valid pulse, with the all-ones result; o_busy drops the cycle after the clear.
REQ-032 SHALL check reset mid-group: rst after 3 samples -> all outputs 0 the next cycle, no o_valid, and the next 4 samples produce a correct group.
